// File: rtl/dsf_pkg.sv
// Shared types and arithmetic helpers for the data_stat_filter block.
// half_tz / div_pow2_tz work on a wide signed type; callers sign-extend
// into it and truncate the result back to their own sample width.
package dsf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned MATH_W = 64;

    typedef logic signed [MATH_W-1:0] wide_t;

    // Width of a running sum over 'depth' samples of 'data_w' bits
    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned depth);
        return data_w + int'($clog2(depth));
    endfunction

    // x / 2 rounded toward zero (arithmetic shift alone would floor)
    function automatic wide_t half_tz(input wide_t x);
        return (x < 0) ? ((x + wide_t'(1)) >>> 1) : (x >>> 1);
    endfunction

    // x / 2**sh rounded toward zero
    function automatic wide_t div_pow2_tz(input wide_t x, input int unsigned sh);
        wide_t bias;
        bias = (wide_t'(1) <<< sh) - wide_t'(1);
        return (x < 0) ? ((x + bias) >>> sh) : (x >>> sh);
    endfunction

endpackage

// File: rtl/dsf_delay_line.sv
// DEPTH-stage sample delay line for data_stat_filter.
// Optional feature macro: DSF_MOVING_AVG_EN adds a running sum of all taps.
// Ports:
//   CLOCK    rising-edge clock
//   RESET    synchronous active-high reset, zeroes taps (and sum)
//   shift    advance the line, din enters tap 1
//   clear    zero taps (and sum); wins over shift
//   din      signed sample in
//   tap_out  oldest tap (TAP[DEPTH])
//   sum_out  sum of TAP[1..DEPTH] (DSF_MOVING_AVG_EN only)
module dsf_delay_line #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     shift,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] din,
`ifdef DSF_MOVING_AVG_EN
    output logic signed [dsf_pkg::sum_w(DATA_W, DEPTH)-1:0] sum_out,
`endif
    output logic signed [DATA_W-1:0] tap_out
);
    import dsf_pkg::*;

    logic signed [DATA_W-1:0] taps [DEPTH];

    // Shift register; taps[0] is TAP[1]
    always_ff @(posedge CLOCK) begin
        if (RESET || clear) begin
            for (int i = 0; i < int'(DEPTH); i++) taps[i] <= '0;
        end else if (shift) begin
            taps[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) taps[i] <= taps[i-1];
        end
    end

    assign tap_out = taps[DEPTH-1];

`ifdef DSF_MOVING_AVG_EN
    localparam int unsigned SUM_W = sum_w(DATA_W, DEPTH);

    logic signed [SUM_W-1:0] sum_q;

    // Incremental window sum: newest sample in, oldest sample out
    always_ff @(posedge CLOCK) begin
        if (RESET || clear) begin
            sum_q <= '0;
        end else if (shift) begin
            sum_q <= sum_q + SUM_W'(din) - SUM_W'(taps[DEPTH-1]);
        end
    end

    assign sum_out = sum_q;
`endif

endmodule

// File: rtl/data_stat_filter.sv
// Streaming running max/min tracker with a delay line and selectable output.
// Optional feature macro: DSF_MOVING_AVG_EN (windowed mean on the AVERAGE path).
// Ports:
//   CLOCK     rising-edge clock
//   RESET     synchronous active-high reset
//   RESTART   output midrange (RMAX+RMIN)/2
//   AVERAGE   with ENABLE, select delayed/windowed value
//   ENABLE    capture DATA_IN as last sample, select average paths
//   CLEAR     return to INIT from RUN
//   DATA_IN   signed sample
//   DATA_OUT  registered result
//   RMAX_OUT  registered running maximum
//   RMIN_OUT  registered running minimum
//   READY     high while in RUN
module data_stat_filter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     RESTART,
    input  logic                     AVERAGE,
    input  logic                     ENABLE,
    input  logic                     CLEAR,
    input  logic signed [DATA_W-1:0] DATA_IN,
    output logic signed [DATA_W-1:0] DATA_OUT,
    output logic signed [DATA_W-1:0] RMAX_OUT,
    output logic signed [DATA_W-1:0] RMIN_OUT,
    output logic                     READY
);
    import dsf_pkg::*;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] data_out_q, data_out_nxt;
    logic signed [DATA_W-1:0] rmax_q, rmax_nxt;
    logic signed [DATA_W-1:0] rmin_q, rmin_nxt;
    logic signed [DATA_W-1:0] rlast_q, rlast_nxt;
    logic                     ready_q;
    logic                     tap_shift_c, tap_clear_c;
    logic signed [DATA_W-1:0] tap_last;
    logic signed [DATA_W-1:0] midrange_c, pair_avg_c, window_c;

`ifdef DSF_MOVING_AVG_EN
    localparam int unsigned SUM_W      = sum_w(DATA_W, DEPTH);
    localparam int unsigned LOG2_DEPTH = $clog2(DEPTH);

    logic signed [SUM_W-1:0] tap_sum;
`endif

    dsf_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_delay_line (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .shift   (tap_shift_c),
        .clear   (tap_clear_c),
        .din     (DATA_IN),
`ifdef DSF_MOVING_AVG_EN
        .sum_out (tap_sum),
`endif
        .tap_out (tap_last)
    );

    // Candidate results; sums are formed wide so they cannot wrap
    assign midrange_c = DATA_W'(half_tz(wide_t'(rmax_q) + wide_t'(rmin_q)));
    assign pair_avg_c = DATA_W'(half_tz(wide_t'(DATA_IN) + wide_t'(tap_last)));
`ifdef DSF_MOVING_AVG_EN
    assign window_c   = DATA_W'(div_pow2_tz(wide_t'(tap_sum), LOG2_DEPTH));
`else
    assign window_c   = tap_last;
`endif

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and datapath next values
    always_comb begin
        state_nxt    = state;
        data_out_nxt = data_out_q;
        rmax_nxt     = rmax_q;
        rmin_nxt     = rmin_q;
        rlast_nxt    = rlast_q;
        tap_shift_c  = 1'b0;
        tap_clear_c  = 1'b0;
        case (state)
            IDLE: state_nxt = INIT;
            INIT: begin
                state_nxt    = RUN;
                rmax_nxt     = DATA_IN;
                rmin_nxt     = DATA_IN;
                rlast_nxt    = '0;
                data_out_nxt = '0;
                tap_clear_c  = 1'b1;
            end
            RUN: begin
                if (CLEAR) begin
                    // Outputs hold; INIT rebuilds the window
                    state_nxt = INIT;
                end else begin
                    tap_shift_c = 1'b1;
                    if (ENABLE) rlast_nxt = DATA_IN;
                    if (RESTART)                 data_out_nxt = midrange_c;
                    else if (ENABLE && AVERAGE)  data_out_nxt = window_c;
                    else if (ENABLE)             data_out_nxt = pair_avg_c;
                    else                         data_out_nxt = rlast_q;
                    if (DATA_IN > rmax_q)        rmax_nxt = DATA_IN;
                    else if (DATA_IN < rmin_q)   rmin_nxt = DATA_IN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            data_out_q <= '0;
            rmax_q     <= '0;
            rmin_q     <= '0;
            rlast_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            data_out_q <= data_out_nxt;
            rmax_q     <= rmax_nxt;
            rmin_q     <= rmin_nxt;
            rlast_q    <= rlast_nxt;
            ready_q    <= (state_nxt == RUN);
        end
    end

    assign DATA_OUT = data_out_q;
    assign RMAX_OUT = rmax_q;
    assign RMIN_OUT = rmin_q;
    assign READY    = ready_q;

endmodule

// File: tb/tb_data_stat_filter.sv
// Directed self-checking bench for data_stat_filter (DATA_W=8, DEPTH=4).
module tb_data_stat_filter;

    logic              CLOCK;
    logic              RESET;
    logic              RESTART;
    logic              AVERAGE;
    logic              ENABLE;
    logic              CLEAR;
    logic signed [7:0] DATA_IN;
    logic signed [7:0] DATA_OUT;
    logic signed [7:0] RMAX_OUT;
    logic signed [7:0] RMIN_OUT;
    logic              READY;

    int tests_run;
    int tests_failed;

    localparam logic signed [7:0] NEG_MAX = 8'sh80;
    localparam logic signed [7:0] POS_MAX = 8'sh7F;
`ifdef DSF_MOVING_AVG_EN
    localparam logic signed [7:0] EXP_WIN_A = 8'sd2;   // (4+3+2+1)/4
    localparam logic signed [7:0] EXP_WIN_B = 8'sd3;   // (5+4+3+2)/4
    localparam logic signed [7:0] EXP_WIN_C = -8'sd2;  // -10/4 toward zero
`else
    localparam logic signed [7:0] EXP_WIN_A = 8'sd1;
    localparam logic signed [7:0] EXP_WIN_B = 8'sd2;
    localparam logic signed [7:0] EXP_WIN_C = -8'sd1;
`endif

    data_stat_filter #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .RESTART  (RESTART),
        .AVERAGE  (AVERAGE),
        .ENABLE   (ENABLE),
        .CLEAR    (CLEAR),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .RMAX_OUT (RMAX_OUT),
        .RMIN_OUT (RMIN_OUT),
        .READY    (READY)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // One clock; outputs sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge CLOCK);
        #1;
    endtask

    // CLEAR from RUN, then INIT loads val
    task automatic reinit(input logic signed [7:0] val);
        RESTART = 1'b0; ENABLE = 1'b0; AVERAGE = 1'b0;
        CLEAR = 1'b1;
        cyc();
        CLEAR = 1'b0; DATA_IN = val;
        cyc();
    endtask

    task automatic test_reset();
        RESET = 1'b1; CLEAR = 1'b0; RESTART = 1'b0; ENABLE = 1'b0; AVERAGE = 1'b0;
        DATA_IN = 8'sd10;
        cyc(); cyc();
        tests_run++;
        if (DATA_OUT !== 8'sd0) begin tests_failed++; $display("FAIL reset_data_out got %0d want 0", DATA_OUT); end
        tests_run++;
        if (READY !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %0b want 0", READY); end
        tests_run++;
        if (RMAX_OUT !== 8'sd0 || RMIN_OUT !== 8'sd0) begin
            tests_failed++; $display("FAIL reset_maxmin got %0d/%0d want 0/0", RMAX_OUT, RMIN_OUT);
        end
        RESET = 1'b0;
        cyc();
        tests_run++;
        if (READY !== 1'b0) begin tests_failed++; $display("FAIL ready_in_init got %0b want 0", READY); end
        cyc();
        tests_run++;
        if (READY !== 1'b1) begin tests_failed++; $display("FAIL ready_in_run got %0b want 1", READY); end
        tests_run++;
        if (RMAX_OUT !== 8'sd10 || RMIN_OUT !== 8'sd10) begin
            tests_failed++; $display("FAIL init_load got %0d/%0d want 10/10", RMAX_OUT, RMIN_OUT);
        end
        tests_run++;
        if (DATA_OUT !== 8'sd0) begin tests_failed++; $display("FAIL init_data_out got %0d want 0", DATA_OUT); end
    endtask

    task automatic test_midrange();
        DATA_IN = 8'sd50;
        cyc();
        tests_run++;
        if (RMAX_OUT !== 8'sd50) begin tests_failed++; $display("FAIL rmax_update got %0d want 50", RMAX_OUT); end
        DATA_IN = -8'sd30; RESTART = 1'b1;
        cyc();
        RESTART = 1'b0;
        tests_run++;
        if (DATA_OUT !== 8'sd30) begin tests_failed++; $display("FAIL midrange_pos got %0d want 30", DATA_OUT); end
        tests_run++;
        if (RMIN_OUT !== -8'sd30) begin tests_failed++; $display("FAIL rmin_update got %0d want -30", RMIN_OUT); end
        reinit(-8'sd7);
        DATA_IN = 8'sd2;
        cyc();
        RESTART = 1'b1;
        cyc();
        RESTART = 1'b0;
        tests_run++;
        if (DATA_OUT !== -8'sd2) begin tests_failed++; $display("FAIL midrange_neg_tz got %0d want -2", DATA_OUT); end
    endtask

    task automatic test_pair_avg();
        reinit(8'sd0);
        ENABLE = 1'b1; AVERAGE = 1'b0; DATA_IN = NEG_MAX;
        repeat (5) cyc();
        tests_run++;
        if (DATA_OUT !== NEG_MAX) begin tests_failed++; $display("FAIL pair_avg_min got %0d want -128", DATA_OUT); end
        DATA_IN = POS_MAX;
        cyc();
        tests_run++;
        if (DATA_OUT !== 8'sd0) begin tests_failed++; $display("FAIL pair_avg_mixed got %0d want 0", DATA_OUT); end
        repeat (4) cyc();
        tests_run++;
        if (DATA_OUT !== POS_MAX) begin tests_failed++; $display("FAIL pair_avg_max got %0d want 127", DATA_OUT); end
    endtask

    task automatic test_window();
        ENABLE = 1'b1; AVERAGE = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            DATA_IN = 8'(i);
            cyc();
        end
        DATA_IN = 8'sd5;
        cyc();
        tests_run++;
        if (DATA_OUT !== EXP_WIN_A) begin tests_failed++; $display("FAIL window_pos got %0d want %0d", DATA_OUT, EXP_WIN_A); end
        DATA_IN = -8'sd1;
        cyc();
        tests_run++;
        if (DATA_OUT !== EXP_WIN_B) begin tests_failed++; $display("FAIL window_slide got %0d want %0d", DATA_OUT, EXP_WIN_B); end
        for (int i = 2; i <= 4; i++) begin
            DATA_IN = -8'(i);
            cyc();
        end
        DATA_IN = 8'sd0;
        cyc();
        tests_run++;
        if (DATA_OUT !== EXP_WIN_C) begin tests_failed++; $display("FAIL window_neg got %0d want %0d", DATA_OUT, EXP_WIN_C); end
    endtask

    task automatic test_hold();
        reinit(8'sd20);
        ENABLE = 1'b1; AVERAGE = 1'b0; DATA_IN = 8'sd42;
        cyc();
        tests_run++;
        if (DATA_OUT !== 8'sd21) begin tests_failed++; $display("FAIL pair_avg_empty got %0d want 21", DATA_OUT); end
        ENABLE = 1'b0; DATA_IN = 8'sd20;
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests_run++;
            if (DATA_OUT !== 8'sd42) begin tests_failed++; $display("FAIL hold_%0d got %0d want 42", i, DATA_OUT); end
        end
        RESTART = 1'b1; ENABLE = 1'b1; AVERAGE = 1'b0; DATA_IN = -8'sd20;
        cyc();
        RESTART = 1'b0;
        tests_run++;
        if (DATA_OUT !== 8'sd31) begin tests_failed++; $display("FAIL restart_priority got %0d want 31", DATA_OUT); end
    endtask

    task automatic test_clear();
        CLEAR = 1'b1; ENABLE = 1'b1; AVERAGE = 1'b0; DATA_IN = 8'sd100;
        cyc();
        tests_run++;
        if (DATA_OUT !== 8'sd31 || RMAX_OUT !== 8'sd42 || RMIN_OUT !== -8'sd20) begin
            tests_failed++;
            $display("FAIL clear_hold got out=%0d max=%0d min=%0d want 31/42/-20", DATA_OUT, RMAX_OUT, RMIN_OUT);
        end
        tests_run++;
        if (READY !== 1'b0) begin tests_failed++; $display("FAIL clear_ready got %0b want 0", READY); end
        CLEAR = 1'b0; DATA_IN = -8'sd5;
        cyc();
        tests_run++;
        if (RMAX_OUT !== -8'sd5 || RMIN_OUT !== -8'sd5 || DATA_OUT !== 8'sd0 || READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_reinit got max=%0d min=%0d out=%0d rdy=%0b want -5/-5/0/1",
                     RMAX_OUT, RMIN_OUT, DATA_OUT, READY);
        end
        ENABLE = 1'b1; AVERAGE = 1'b1; DATA_IN = 8'sd9;
        cyc();
        tests_run++;
        if (DATA_OUT !== 8'sd0) begin tests_failed++; $display("FAIL clear_taps got %0d want 0", DATA_OUT); end
        tests_run++;
        if (RMAX_OUT !== 8'sd9) begin tests_failed++; $display("FAIL clear_rmax got %0d want 9", RMAX_OUT); end
        RESTART = 1'b1; ENABLE = 1'b0; AVERAGE = 1'b0; DATA_IN = 8'sd0;
        cyc();
        RESTART = 1'b0;
        tests_run++;
        if (DATA_OUT !== 8'sd2) begin tests_failed++; $display("FAIL midrange_after_clear got %0d want 2", DATA_OUT); end
    endtask

    task automatic test_reset_clear();
        RESET = 1'b1; CLEAR = 1'b1;
        cyc();
        tests_run++;
        if (DATA_OUT !== 8'sd0 || RMAX_OUT !== 8'sd0 || RMIN_OUT !== 8'sd0 || READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_over_clear got out=%0d max=%0d min=%0d rdy=%0b want 0/0/0/0",
                     DATA_OUT, RMAX_OUT, RMIN_OUT, READY);
        end
        // CLEAR held through IDLE and INIT must not stall sequencing
        RESET = 1'b0; DATA_IN = 8'sd3;
        cyc(); cyc();
        CLEAR = 1'b0;
        tests_run++;
        if (READY !== 1'b1 || RMAX_OUT !== 8'sd3 || RMIN_OUT !== 8'sd3) begin
            tests_failed++;
            $display("FAIL clear_ignored_init got rdy=%0b max=%0d min=%0d want 1/3/3", READY, RMAX_OUT, RMIN_OUT);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_midrange();
        test_pair_avg();
        test_window();
        test_hold();
        test_clear();
        test_reset_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_stat_filter.md
Name: data_stat_filter

Overview:
- Parametrised successor of the team's single-channel running-statistics processor.
- Streams a signed sample every cycle and tracks the running max and min.
- Keeps a DEPTH-stage sample delay line and drives one output per cycle: midrange, pair-average, delayed sample, or held last sample.
- Adds over the previous generation: width and depth parameters, a synchronous CLEAR back to init, READY and max/min observability, and an optional windowed moving average.

Parameters:
- DATA_W, 8, sample width in bits (signed two's complement, >=4).
- DEPTH, 4, delay-line length (power of 2, >=2).

Ports:
- CLOCK  in  1  rising-edge clock
- RESET  in  1  synchronous active-high reset
- RESTART  in  1  output midrange (RMAX+RMIN)/2 this cycle
- AVERAGE  in  1  with ENABLE: output delayed/windowed value instead of pair-average
- ENABLE  in  1  accept DATA_IN as last sample; select average paths
- CLEAR  in  1  synchronous return to INIT without full reset
- DATA_IN  in  DATA_W  signed sample
- DATA_OUT  out  DATA_W  signed registered result
- RMAX_OUT  out  DATA_W  registered running maximum
- RMIN_OUT  out  DATA_W  registered running minimum
- READY  out  1  high while in RUN

Behaviour:
- Clock and reset: one clock, CLOCK. RESET is synchronous and active-high. All state updates on the CLOCK rising edge.
- Reset: RESET=1 sets the following, all zero:
  - state=IDLE
  - DATA_OUT, RMAX, RMIN, RLAST, all taps
  - READY
- Precedence: RESET > CLEAR > normal operation.
- State machine:
  - IDLE -> INIT unconditionally.
  - INIT -> RUN: load RMAX=RMIN=DATA_IN; clear taps and RLAST; DATA_OUT=0.
  - RUN -> RUN; RUN -> INIT when CLEAR=1.
  - CLEAR=1 in RUN: DATA_OUT, RMAX, RMIN hold that cycle. CLEAR in IDLE/INIT is ignored.
- READY: registered, 1 exactly on cycles where state=RUN.
- RUN cycle, all decisions on current-cycle inputs:
  - If ENABLE: RLAST <= DATA_IN.
  - DATA_OUT priority:
    1. RESTART=1: DATA_OUT <= half(RMAX+RMIN), using RMAX/RMIN as registered before this edge.
    2. ENABLE=1, AVERAGE=1: DATA_OUT <= TAP[DEPTH] (sample from DEPTH RUN cycles ago).
    3. ENABLE=1, AVERAGE=0: DATA_OUT <= half(DATA_IN+TAP[DEPTH]).
    4. Otherwise: DATA_OUT <= RLAST (pre-edge value).
  - Max/min: if DATA_IN>RMAX then RMAX<=DATA_IN; else if DATA_IN<RMIN then RMIN<=DATA_IN.
  - Delay line: TAP[k]<=TAP[k-1], TAP[1]<=DATA_IN.
- Arithmetic: half(x) computes the sum at DATA_W+1 bits and divides by 2 truncating toward zero. The result always fits DATA_W, so no saturation or wrap is needed.
- Latency: DATA_OUT is one cycle after its inputs.
- Delay-line fill: taps read 0 until filled. This is required behaviour, not an error.
- Reset or CLEAR mid-run: discards the window; the first RUN output after re-entry uses zeroed taps.

Optional Feature:
- Macro: DSF_MOVING_AVG_EN.
- Defined: path 2 (ENABLE=1, AVERAGE=1) outputs mean(TAP[1..DEPTH]).
  - Running sum of DATA_W+log2(DEPTH) bits, updated incrementally: +DATA_IN, -TAP[DEPTH].
  - Sum cleared with the taps.
  - Divide by DEPTH truncating toward zero.
- Undefined: path 2 outputs TAP[DEPTH]; no sum register exists.

Decomposition:
- Package dsf_pkg holds:
  - state enum {IDLE, INIT, RUN}
  - function half_tz (halve, truncate toward zero)
  - function div_pow2_tz
  - localparam helpers for sum width
- Sub-module dsf_delay_line (parameters DATA_W, DEPTH; ports shift/clear/din/tap_out, optional sum_out). Natural split; the top keeps the FSM, max/min and output mux.

Test Plan (DATA_W=8, DEPTH=4):
- Reset/sequencing: RESET=1 two cycles -> DATA_OUT=0, READY=0. Release with DATA_IN=10 held -> READY=1 on the second edge after release; RMAX_OUT=RMIN_OUT=10.
- Midrange: after init at 10, feed 50 then -30, then RESTART=1 -> DATA_OUT=(50+10)/2=30. Init at -7, feed 2, RESTART -> -5/2 = -2 (toward zero, not -3).
- Pair-average extremes: fill taps with -128, ENABLE=1, AVERAGE=0, DATA_IN=-128 -> DATA_OUT=-128. Taps 127, DATA_IN=127 -> 127. No wrap.
- Delay/window: ENABLE=1, AVERAGE=1, feed 1,2,3,4, then 5 -> DATA_OUT=1 (macro off) or 10/4=2 (macro on). Feeding -1,-2,-3,-4 then any sample -> -1 (macro off) or -10/4=-2 (macro on).
- Hold and precedence: ENABLE=1 with 42, then ENABLE=0 for 3 cycles -> DATA_OUT=42 each cycle. RESTART=1 with ENABLE=1 -> midrange wins.
- CLEAR mid-run: CLEAR=1 in RUN -> outputs hold one cycle, then INIT loads RMAX=RMIN=DATA_IN. Next AVERAGE path reads 0 from the cleared taps. CLEAR and RESET together -> reset result.
